// File: rtl/booth_mult_sequencer.sv
// booth_mult_sequencer
// Front-end and result collector for an N-bit radix-4 Booth multiplier that
// needs N/2 iterations. Operand pairs are buffered in a DEPTH-entry FIFO, one
// job at a time is loaded into the multiplier, its fixed latency is counted
// out, and the 2N-bit product is held on a valid/ready output port.
// Optional feature: define BOOTH_SEQ_ZERO_BYPASS_EN to answer pairs with a
// zero operand directly (out_p=0 one cycle after the pop) without loading the
// multiplier.

module booth_mult_sequencer #(
    parameter int N     = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic           mul_load,
    output logic [N-1:0]   mul_op1,
    output logic [N-1:0]   mul_op2,
    input  logic [2*N-1:0] mul_p,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_p,
    output logic           busy
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = $clog2(N / 2 + 2);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    // Multiplier needs N/2 iterations after load drops; one extra cycle of margin
    localparam logic [WAIT_W-1:0] WAIT_DONE  = WAIT_W'(N / 2 + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WAIT_W-1:0]   r_cnt;

    logic [N-1:0]        r_mem_a [DEPTH];
    logic [N-1:0]        r_mem_b [DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    w_count_next;
    logic                r_in_ready;

    logic [N-1:0]        r_op1;
    logic [N-1:0]        r_op2;
    logic                r_out_valid;
    logic [2*N-1:0]      r_out_p;

    logic                w_push;
    logic                w_pop;
    logic                w_bypass;
    logic                w_capture;
    logic                w_mul_load;
    logic                w_head_zero;
    logic                w_fifo_nonempty;

    assign w_push          = in_valid && r_in_ready;
    assign w_fifo_nonempty = (r_count != '0);

`ifdef BOOTH_SEQ_ZERO_BYPASS_EN
    assign w_head_zero = (r_mem_a[r_rd_ptr] == '0) || (r_mem_b[r_rd_ptr] == '0);
`else
    assign w_head_zero = 1'b0;
`endif

    // FIFO storage write; data is only ever read under a non-zero count
    // NOTE: the storage array has no reset; pointers and count define validity, so resetting it would only add muxes.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= in_a;
            r_mem_b[r_wr_ptr] <= in_b;
        end
    end

    // Next occupancy: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // FIFO pointers, occupancy and registered in_ready (low while in reset)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next != FULL_COUNT);
        end
    end

    // Job FSM state register and latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_LOAD)      r_cnt <= '0;
            else if (r_state == S_WAIT) r_cnt <= r_cnt + WAIT_W'(1);
        end
    end

    // Job FSM next state and strobes; a pending result blocks new jobs
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_bypass     = 1'b0;
        w_capture    = 1'b0;
        w_mul_load   = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_fifo_nonempty && !r_out_valid) begin
                    w_pop = 1'b1;
                    if (w_head_zero) w_bypass     = 1'b1;
                    else             w_state_next = S_LOAD;
                end
            end
            S_LOAD: w_state_next = S_WAIT;
            S_WAIT: begin
                w_mul_load = 1'b0;
                if (r_cnt == WAIT_DONE) begin
                    w_capture    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand registers feeding the multiplier; held until the next real job
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op1 <= '0;
            r_op2 <= '0;
        end else if (w_pop && !w_bypass) begin
            r_op1 <= r_mem_a[r_rd_ptr];
            r_op2 <= r_mem_b[r_rd_ptr];
        end
    end

    // Result holding register: set by capture or bypass, cleared on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
            r_out_p     <= mul_p;
        end else if (w_bypass) begin
            r_out_valid <= 1'b1;
            r_out_p     <= '0;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign mul_load  = w_mul_load;
    assign mul_op1   = r_op1;
    assign mul_op2   = r_op2;
    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;
    assign busy      = (r_state != S_IDLE) || w_fifo_nonempty;

endmodule
